// File: rtl/z_result_stage_pkg.sv
// z_result_stage_pkg: ALU opcodes, stage state encoding and opcode helper shared by the Z result stage.
package z_result_stage_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WAIT_DIV, S_ERR} state_e;
  function automatic logic is_wide(input logic [4:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/z_result_stage_if.sv
// z_result_stage_if: control/ALU-facing signals of the Z result stage; flag outputs exist only with Z_STAGE_FLAGS_EN.
interface z_result_stage_if;
  logic        start;
  logic [4:0]  op_sel;
  logic [31:0] zhigh_in;
  logic [31:0] zlo_in;
  logic        calc_finished;
  logic [31:0] zhigh_out;
  logic [31:0] zlo_out;
  logic        busy;
  logic        done;
  logic        hi_we;
  logic        timeout_err;
`ifdef Z_STAGE_FLAGS_EN
  logic        zero_flag;
  logic        neg_flag;
  modport master (output start, op_sel, zhigh_in, zlo_in, calc_finished,
                  input zhigh_out, zlo_out, busy, done, hi_we, timeout_err, zero_flag, neg_flag);
  modport slave  (input start, op_sel, zhigh_in, zlo_in, calc_finished,
                  output zhigh_out, zlo_out, busy, done, hi_we, timeout_err, zero_flag, neg_flag);
`else
  modport master (output start, op_sel, zhigh_in, zlo_in, calc_finished,
                  input zhigh_out, zlo_out, busy, done, hi_we, timeout_err);
  modport slave  (input start, op_sel, zhigh_in, zlo_in, calc_finished,
                  output zhigh_out, zlo_out, busy, done, hi_we, timeout_err);
`endif
endinterface

// File: rtl/z_stage_timer.sv
// z_stage_timer: divider wait counter; expired flags the last permitted wait cycle and the count saturates there.
module z_stage_timer #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q >= W'(TIMEOUT - 1);
  always_comb cnt_d = clear ? '0 : (expired ? cnt_q : cnt_q + W'(1));
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/z_result_stage.sv
// z_result_stage: registers the ALU Z result after single-cycle ops or divider completion; Z_STAGE_FLAGS_EN adds zero/neg flags.
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input logic             clk,
  input logic             reset,
  z_result_stage_if.slave zif
);
  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] zhi_q, zhi_d, zlo_q, zlo_d;
  logic        done_q, done_d, hi_we_q, hi_we_d, terr_q, terr_d;
  logic        load, expired;
`ifdef Z_STAGE_FLAGS_EN
  logic        zero_q, zero_d, neg_q, neg_d;
`endif
  z_stage_timer #(.TIMEOUT(DIV_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != S_WAIT_DIV),
    .expired (expired)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    done_d  = 1'b0;
    hi_we_d = 1'b0;
    terr_d  = terr_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (zif.start) begin
        op_d    = zif.op_sel;
        terr_d  = 1'b0;
        state_d = zif.op_sel == OP_DIV ? S_WAIT_DIV : S_CAPTURE;
      end
      S_CAPTURE:  load = 1'b1;
      // a divider completion on the expiry edge still counts as a normal capture
      S_WAIT_DIV: if (zif.calc_finished) load = 1'b1; else if (expired) state_d = S_ERR;
      S_ERR: begin
        terr_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      zhi_d   = zif.zhigh_in;
      zlo_d   = zif.zlo_in;
      done_d  = 1'b1;
      hi_we_d = is_wide(op_q);
      state_d = S_IDLE;
    end
  end
`ifdef Z_STAGE_FLAGS_EN
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (load) begin
      zero_d = zif.zlo_in == '0 && (!is_wide(op_q) || zif.zhigh_in == '0);
      neg_d  = op_q == OP_MUL ? zif.zhigh_in[31] : zif.zlo_in[31];
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  assign zif.zero_flag = zero_q;
  assign zif.neg_flag  = neg_q;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      done_q  <= 1'b0;
      hi_we_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      done_q  <= done_d;
      hi_we_q <= hi_we_d;
      terr_q  <= terr_d;
    end
  assign zif.zhigh_out   = zhi_q;
  assign zif.zlo_out     = zlo_q;
  assign zif.busy        = state_q != S_IDLE;
  assign zif.done        = done_q;
  assign zif.hi_we       = hi_we_q;
  assign zif.timeout_err = terr_q;
endmodule

// File: tb/tb_z_result_stage.sv
// tb_z_result_stage: directed plus randomized checks of z_result_stage against a transaction-level model (Z_STAGE_FLAGS_EN adds flag checks).
module tb_z_result_stage;
  localparam int T = 40;
  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, DIV = 5'b01111, MUL = 5'b10000;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  z_result_stage_if zif();
  z_result_stage #(.DIV_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .zif(zif));
  int passed = 0, total = 0;
  logic [31:0] e_hi = '0, e_lo = '0;
  logic        e_terr = 1'b0, e_zero = 1'b0, e_neg = 1'b0;
  logic [4:0]  ops [16] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                            5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10001, 5'b10010};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_zhigh"}, 64'(zif.zhigh_out), 64'(e_hi));
    chk({tag, "_zlo"}, 64'(zif.zlo_out), 64'(e_lo));
    chk({tag, "_terr"}, 64'(zif.timeout_err), 64'(e_terr));
`ifdef Z_STAGE_FLAGS_EN
    chk({tag, "_zero"}, 64'(zif.zero_flag), 64'(e_zero));
    chk({tag, "_neg"}, 64'(zif.neg_flag), 64'(e_neg));
`endif
  endtask

  // k: edges after the start edge before calc_finished is raised; inject: try a second start while busy
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] hi, input logic [31:0] lo,
                        input int k, input bit inject);
    int  n = 0, exp_n;
    bit  got = 1'b0, wide, tmo;
    wide  = op == MUL || op == DIV;
    tmo   = op == DIV && k + 1 > T;
    exp_n = op != DIV ? 2 : (tmo ? T + 2 : k + 2);
    zif.start = 1'b1; zif.op_sel = op; zif.zhigh_in = hi; zif.zlo_in = lo; zif.calc_finished = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        chk({tag, "_terr_clr"}, 64'(zif.timeout_err), 64'(0));
        chk({tag, "_busy"}, 64'(zif.busy), 64'(1));
        zif.start = inject; zif.op_sel = ADD;
      end
      if (n == 2) zif.start = 1'b0;
      if (zif.done) got = 1'b1;
      else if (op == DIV && n == k + 1) zif.calc_finished = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'(1));
    chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    e_terr = tmo;
    if (!tmo) begin
      e_hi = hi; e_lo = lo;
      e_zero = lo == 0 && (!wide || hi == 0);
      e_neg  = op == MUL ? hi[31] : lo[31];
    end
    chk({tag, "_hi_we"}, 64'(zif.hi_we), 64'(wide && !tmo));
    check_outs(tag);
    zif.calc_finished = 1'b0;
    zif.zhigh_in = $urandom; zif.zlo_in = $urandom;
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 64'({zif.done, zif.hi_we, zif.busy}), 64'(0));
    check_outs({tag, "_hold"});
  endtask

  initial begin
    int aborted_done = 0;
    zif.start = 1'b0; zif.op_sel = '0; zif.zhigh_in = '0; zif.zlo_in = '0; zif.calc_finished = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 64'({zif.busy, zif.done, zif.hi_we}), 64'(0));
    check_outs("rst");
    reset = 1'b0;
    run_op("add", ADD, 32'h0, 32'h5, 0, 1'b0);
    run_op("mul", MUL, 32'h1, 32'h8000_0000, 0, 1'b1);
    run_op("div33", DIV, 32'h2, 32'h7, 33, 1'b1);
    run_op("div_edge", DIV, 32'h3, 32'h9, T - 1, 1'b0);
    run_op("div_tmo", DIV, 32'h5, 32'h6, 1000, 1'b0);
    run_op("sub_neg", SUB, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("sub_zero", SUB, 32'h0, 32'h0, 0, 1'b0);
    run_op("mul_zero", MUL, 32'h0, 32'h0, 0, 1'b0);
    for (int i = 0; i < 10; i++)
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(15)], $urandom,
             $urandom_range(3) == 0 ? 32'h0 : $urandom, int'($urandom_range(45)), 1'($urandom_range(1)));
    zif.start = 1'b1; zif.op_sel = DIV; zif.zhigh_in = 32'h1234; zif.zlo_in = 32'h5678;
    @(posedge clk); #1;
    zif.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (zif.done) aborted_done++;
    end
    reset = 1'b1; zif.start = 1'b1; zif.op_sel = ADD;
    @(posedge clk); #1;
    e_hi = '0; e_lo = '0; e_terr = 1'b0; e_zero = 1'b0; e_neg = 1'b0;
    chk("abort_flags", 64'({zif.busy, zif.done, zif.hi_we}), 64'(0));
    check_outs("abort");
    reset = 1'b0; zif.start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (zif.done) aborted_done++;
    end
    chk("abort_no_done", 64'(aborted_done), 64'(0));
    chk("abort_idle", 64'(zif.busy), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/z_result_stage.md
Z_RESULT_STAGE -- requirements
Module: z_result_stage

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 40, the maximum number of cycles spent waiting for the divider.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: pulse from the control unit issuing an ALU operation.
REQ-005 SHALL have port op_sel, input, 5 bits: ALU operation code, sampled with start.
REQ-006 SHALL have ports zhigh_in and zlo_in, inputs, 32 bits each: combinational ALU result halves.
REQ-007 SHALL have port calc_finished, input, 1 bit: divider completion from the ALU.
REQ-008 SHALL have ports zhigh_out and zlo_out, outputs, 32 bits each: registered Z result.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a result is loaded or a timeout occurs.
REQ-011 SHALL have port hi_we, output, 1 bit: pulses with done for MUL/DIV captures only.
REQ-012 SHALL have port timeout_err, output, 1 bit: sticky divider-timeout flag.

Function
REQ-013 SHALL implement states IDLE, CAPTURE, WAIT_DIV and ERR.
REQ-014 In IDLE with start=1, SHALL latch op_sel; next state WAIT_DIV if op_sel=5'b01111 (DIV), else CAPTURE.
REQ-015 CAPTURE SHALL load zhigh_out/zlo_out from zhigh_in/zlo_in, pulse done in the following cycle, and return to IDLE (done two edges after start).
REQ-016 On entry to WAIT_DIV, SHALL clear the wait counter, then increment it once per cycle.
REQ-017 In WAIT_DIV, calc_finished sampled high SHALL load outputs, pulse done and hi_we next cycle, and return to IDLE.
REQ-018 In WAIT_DIV, counter reaching DIV_TIMEOUT with calc_finished low SHALL go to ERR; calc_finished high on that same edge SHALL win (normal capture).
REQ-019 ERR SHALL set timeout_err, pulse done, leave zhigh_out/zlo_out unchanged, and return to IDLE after one cycle.
REQ-020 hi_we SHALL pulse only for latched op 5'b10000 (MUL) or 5'b01111 (DIV).
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 timeout_err SHALL clear only on reset or on the next accepted start.
REQ-023 Outputs SHALL hold their values between captures.

Reset
REQ-024 reset SHALL force state IDLE, zhigh_out=0, zlo_out=0, busy=0, done=0, hi_we=0, timeout_err=0 and counter=0.
REQ-025 reset asserted mid-operation SHALL abort it with no done pulse; reset SHALL take priority over start.

Configuration
REQ-026 Macro Z_STAGE_FLAGS_EN defined SHALL add outputs zero_flag and neg_flag (1 bit each), registered with each capture: zero_flag = (zlo_in==0) and, for MUL/DIV, also (zhigh_in==0); neg_flag = bit 31 of zlo_in (bit 63, i.e. zhigh_in[31], for MUL). Both reset to 0.
REQ-027 Without Z_STAGE_FLAGS_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 The shared package SHALL hold the opcode constants (OP_ADD 5'b00011 through OP_NOT 5'b10010, including OP_MUL and OP_DIV) and the state enum typedef.
REQ-029 The wait counter and timeout compare SHALL be the single sub-module z_stage_timer (ports: clk, reset, clear, expired).

Verification
REQ-030 ADD: start with op 5'b00011, zlo_in=0x00000005, zhigh_in=0 -> done two edges later; zlo_out=5; hi_we=0.
REQ-031 MUL: op 5'b10000, zhigh_in=0x00000001, zlo_in=0x80000000 -> done and hi_we pulse together; zhigh_out=1.
REQ-032 DIV: op 5'b01111, calc_finished raised 33 cycles after start, zlo_in=7, zhigh_in=2 -> done the cycle after; zlo_out=7, zhigh_out=2.
REQ-033 DIV timeout: calc_finished held low -> ERR after 40 cycles; timeout_err=1; outputs unchanged; next start clears timeout_err.
REQ-034 Reset at WAIT_DIV cycle 10 -> no done pulse, all outputs 0; a second start during busy is ignored.
REQ-035 With Z_STAGE_FLAGS_EN: SUB result zlo_in=0xFFFFFFFF -> neg_flag=1, zero_flag=0; result 0 -> zero_flag=1.
